read: RTL and testbench
=======================

# read

- Operand-fetch stage of the core, the counterpart of the `write` (writeback) stage.
- On an `enable` pulse it latches up to three source-register specifiers and reads them from the integer and float register files through one read port per file.
- It forwards results that `write` is committing in the same window, so captured operands are never stale.
- It presents the three operands and pulses `done` for one cycle.

## Interface
Parameters: none.

- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `enable`  in  1  start pulse; sampled only in IDLE
- `done`  out  1  one-cycle pulse; data1..data3 valid
- `rselector`  in  6  {sel3,sel2,sel1}, each 2 bits: 0 unused, 1 integer, 2 float, 3 unused
- `rs1`, `rs2`, `rs3`  in  5 each  source register numbers
- `rgenable`  out  1  integer RF read request
- `rgreg`  out  5  integer RF read address
- `rgdata`  in  32  integer RF data, valid the cycle after the request
- `rfenable`, `rfreg`, `rfdata`  out/out/in  1/5/32  same protocol for the float RF
- `wgenable`, `wgreg`, `wgdata`  in  1/5/32  snoop of `write` integer write port
- `wfenable`, `wfreg`, `wfdata`  in  1/5/32  snoop of `write` float write port
- `data1`, `data2`, `data3`  out  32 each  fetched operands

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE + `enable` behaviour:
  - Latch the selectors and `rs1..rs3`.
  - Clear `data1..3` to 0.
  - Build a pending list per file in operand order 1,2,3.
  - Go to ISSUE, or to DONE if both lists are empty.
- Pending-list exclusions:
  - Unused operands (sel 0 or 3) are not added and keep data = 0.
  - An integer operand with rs = 0 is not added and keeps data = 0.
  - Float f0 is an ordinary register and is added.
- ISSUE, each cycle:
  - Issue the head of each non-empty list: `rgenable`=1/`rgreg`=rs for integer, `rfenable`/`rfreg` for float.
  - Capture the read issued in the previous cycle into its operand register.
  - Go to DONE after the capture edge of the last outstanding read.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Forwarding is evaluated per operand:
  - At the issue edge: if the matching write port is enabled with the same register, record its data. Integer never forwards for register 0.
  - At the capture edge: a matching write overrides again (latest wins). Otherwise the recorded data is used if one was recorded, else the RF data.
- If one register feeds two operands, each operand is read and forwarded independently.
- `enable` outside IDLE is ignored.
- `data1..3` hold their values from DONE until the next accepted `enable`.

## Timing
- Cycle 0 is the cycle with `enable`=1 in IDLE.
- k = max(#integer reads, #float reads).
- k=0: `done` in cycle 1.
- k≥1:
  - Issues occur in cycles 1..k.
  - Captures occur at the end of cycles 2..k+1.
  - `done` is high in cycle k+2.
- Request strobes are high only in issue cycles. Outside ISSUE, `rgreg`/`rfreg` return to 0.
- Back-to-back operation: the earliest next `enable` accepted is the cycle after DONE.
- Reset values: `done`=0, `rgenable`=0, `rgreg`=0, `rfenable`=0, `rfreg`=0, `data1..3`=0; state IDLE.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately.
  - No further strobes appear.
  - `done` is not produced.
  - Pending reads are discarded.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, no strobes.
- sel = int,int,int; rs = 3,4,5; RF returns 0x33/0x44/0x55 → `rgreg` 3,4,5 in cycles 1-3; `done` in cycle 5; data = 0x33,0x44,0x55.
- sel = int,float,int; rs = 1,2,6 → rg issues 1,6 in cycles 1-2; rf issues 2 in cycle 1; `done` in cycle 4.
- sel = int,unused,unused with rs1 = 0 → no strobes; `done` in cycle 1; data1..3 = 0.
- Forwarding case: rs1 = 7 int, RF returns 0xAAAA.
  - `wgenable`, `wgreg`=7, `wgdata`=0x1234 in the issue cycle → data1 = 0x1234.
  - 0x5678 also written in the capture cycle → data1 = 0x5678.
  - Float f0 write during capture → forwarded. Integer x0 write → not forwarded.
- Robustness: `enable` pulsed during ISSUE → ignored; `rstn` low in cycle 2 of a 3-read fetch → strobes drop immediately, no `done`; a fresh `enable` after reset completes normally.

Source files
------------

// File: rtl/read.sv
// Operand-fetch stage: reads up to three source operands from the integer and float register
// files through one read port each, forwarding results the writeback stage commits meanwhile.
module read (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        done,
  input  logic [5:0]  rselector,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rs3,
  output logic        rgenable,
  output logic [4:0]  rgreg,
  input  logic [31:0] rgdata,
  output logic        rfenable,
  output logic [4:0]  rfreg,
  input  logic [31:0] rfdata,
  input  logic        wgenable,
  input  logic [4:0]  wgreg,
  input  logic [31:0] wgdata,
  input  logic        wfenable,
  input  logic [4:0]  wfreg,
  input  logic [31:0] wfdata,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0][4:0]   rs_q, rs_d;
  logic [2:0][31:0]  data_q, data_d;
  // Pending operands per register file; the lowest set bit is the next read to issue.
  logic [2:0]        ipend_q, ipend_d, fpend_q, fpend_d;
  // Read in flight (issued last cycle): operand index and any value forwarded at issue.
  logic              iv_q, iv_d, fv_q, fv_d;
  logic [1:0]        iop_q, iop_d, fop_q, fop_d;
  logic              ifv_q, ifv_d, ffv_q, ffv_d;
  logic [31:0]       ifd_q, ifd_d, ffd_q, ffd_d;

  logic [1:0]        ihead, fhead;
  logic [2:0][4:0]   rs_in;

  function automatic logic [1:0] first_set(input logic [2:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  assign ihead = first_set(ipend_q);
  assign fhead = first_set(fpend_q);
  assign rs_in = {rs3, rs2, rs1};

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ipend_d = ipend_q;
    fpend_d = fpend_q;
    iv_d    = 1'b0;
    fv_d    = 1'b0;
    iop_d   = iop_q;
    fop_d   = fop_q;
    ifv_d   = 1'b0;
    ffv_d   = 1'b0;
    ifd_d   = ifd_q;
    ffd_d   = ffd_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          rs_d    = rs_in;
          data_d  = '0;
          ipend_d = '0;
          fpend_d = '0;
          for (int i = 0; i < 3; i++) begin
            if (rselector[2*i +: 2] == 2'd1 && rs_in[i] != 5'd0) ipend_d[i] = 1'b1;
            if (rselector[2*i +: 2] == 2'd2) fpend_d[i] = 1'b1;
          end
          state_d = (ipend_d == '0 && fpend_d == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        // Capture: a write landing now beats anything recorded at issue time.
        if (iv_q) begin
          if (wgenable && wgreg == rs_q[iop_q] && rs_q[iop_q] != 5'd0) data_d[iop_q] = wgdata;
          else if (ifv_q) data_d[iop_q] = ifd_q;
          else data_d[iop_q] = rgdata;
        end
        if (fv_q) begin
          if (wfenable && wfreg == rs_q[fop_q]) data_d[fop_q] = wfdata;
          else if (ffv_q) data_d[fop_q] = ffd_q;
          else data_d[fop_q] = rfdata;
        end
        if (ipend_q != '0) begin
          ipend_d[ihead] = 1'b0;
          iv_d  = 1'b1;
          iop_d = ihead;
          ifv_d = wgenable && wgreg == rs_q[ihead] && rs_q[ihead] != 5'd0;
          ifd_d = wgdata;
        end
        if (fpend_q != '0) begin
          fpend_d[fhead] = 1'b0;
          fv_d  = 1'b1;
          fop_d = fhead;
          ffv_d = wfenable && wfreg == rs_q[fhead];
          ffd_d = wfdata;
        end
        // Nothing left to issue means this cycle only captures the final read.
        if (ipend_q == '0 && fpend_q == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      rs_q    <= '0;
      data_q  <= '0;
      ipend_q <= '0;
      fpend_q <= '0;
      iv_q    <= 1'b0;
      fv_q    <= 1'b0;
      iop_q   <= '0;
      fop_q   <= '0;
      ifv_q   <= 1'b0;
      ffv_q   <= 1'b0;
      ifd_q   <= '0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ipend_q <= ipend_d;
      fpend_q <= fpend_d;
      iv_q    <= iv_d;
      fv_q    <= fv_d;
      iop_q   <= iop_d;
      fop_q   <= fop_d;
      ifv_q   <= ifv_d;
      ffv_q   <= ffv_d;
      ifd_q   <= ifd_d;
      ffd_q   <= ffd_d;
    end
  end

  always_comb begin
    rgenable = (state_q == StIssue) && (ipend_q != '0);
    rfenable = (state_q == StIssue) && (fpend_q != '0);
    rgreg    = rgenable ? rs_q[ihead] : 5'd0;
    rfreg    = rfenable ? rs_q[fhead] : 5'd0;
    done     = (state_q == StDone);
  end

  assign data1 = data_q[0];
  assign data2 = data_q[1];
  assign data3 = data_q[2];

endmodule

// File: tb/tb_read.sv
// Bench for the operand-fetch stage: acts as both register files and checks strobes, done timing
// and operand values against a timing-rule model of the fetch.
module tb_read;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        done;
  logic [5:0]  rselector;
  logic [4:0]  rs1, rs2, rs3;
  logic        rgenable, rfenable;
  logic [4:0]  rgreg, rfreg;
  logic [31:0] rgdata, rfdata;
  logic        wgenable, wfenable;
  logic [4:0]  wgreg, wfreg;
  logic [31:0] wgdata, wfdata;
  logic [31:0] data1, data2, data3;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] irf [32];
  logic [31:0] frf [32];
  logic        wg_en [8];
  logic [4:0]  wg_r  [8];
  logic [31:0] wg_d  [8];
  logic        wf_en [8];
  logic [4:0]  wf_r  [8];
  logic [31:0] wf_d  [8];
  int          mid_en_cyc;

  always #5 clk = ~clk;

  read dut (
    .clk(clk), .rstn(rstn), .enable(enable), .done(done), .rselector(rselector),
    .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .rgenable(rgenable), .rgreg(rgreg), .rgdata(rgdata),
    .rfenable(rfenable), .rfreg(rfreg), .rfdata(rfdata),
    .wgenable(wgenable), .wgreg(wgreg), .wgdata(wgdata),
    .wfenable(wfenable), .wfreg(wfreg), .wfdata(wfdata),
    .data1(data1), .data2(data2), .data3(data3)
  );

  task automatic clear_wr();
    for (int i = 0; i < 8; i++) begin
      wg_en[i] = 1'b0; wg_r[i] = '0; wg_d[i] = '0;
      wf_en[i] = 1'b0; wf_r[i] = '0; wf_d[i] = '0;
    end
    mid_en_cyc = -1;
  endtask

  task automatic drive_quiet();
    enable = 1'b0; wgenable = 1'b0; wfenable = 1'b0;
    wgreg = '0; wfreg = '0; wgdata = '0; wfdata = '0;
  endtask

  // Idle cycles: no strobes, no done.
  task automatic idle(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      drive_quiet();
      @(posedge clk); #1;
      vectors++;
      if (rgenable !== 1'b0 || rfenable !== 1'b0 || done !== 1'b0 || rgreg !== 5'd0 ||
          rfreg !== 5'd0)
        begin
          errors++;
          $display("FAIL %s idle: rgen=%b rg=%0d rfen=%b rf=%0d done=%b, required all 0",
                   tag, rgenable, rgreg, rfenable, rfreg, done);
        end
    end
  endtask

  // One fetch starting with enable in the current cycle (cycle 0). Returns in the cycle after DONE.
  task automatic run_fetch(input logic [5:0] sel, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] r3, input string tag);
    logic [4:0]  rsv [3];
    logic [31:0] expd [3];
    logic [31:0] got [3];
    logic        exp_ge [8], exp_fe [8];
    logic [4:0]  exp_gr [8], exp_fr [8];
    logic        last_ge, last_fe;
    logic [4:0]  last_gr, last_fr;
    int ni, nf, k, dc, iss, cap;
    rsv = '{r1, r2, r3};
    for (int c = 0; c < 8; c++) begin
      exp_ge[c] = 1'b0; exp_fe[c] = 1'b0; exp_gr[c] = '0; exp_fr[c] = '0;
    end
    ni = 0; nf = 0;
    // Operand j is the p-th read of its file: issued in cycle p+1, captured at end of cycle p+2.
    for (int j = 0; j < 3; j++) begin
      expd[j] = 32'd0;
      if (sel[2*j +: 2] == 2'd1 && rsv[j] != 5'd0) begin
        iss = ni + 1; cap = ni + 2; ni++;
        exp_ge[iss] = 1'b1; exp_gr[iss] = rsv[j];
        if (wg_en[cap] && wg_r[cap] == rsv[j]) expd[j] = wg_d[cap];
        else if (wg_en[iss] && wg_r[iss] == rsv[j]) expd[j] = wg_d[iss];
        else expd[j] = irf[rsv[j]];
      end else if (sel[2*j +: 2] == 2'd2) begin
        iss = nf + 1; cap = nf + 2; nf++;
        exp_fe[iss] = 1'b1; exp_fr[iss] = rsv[j];
        if (wf_en[cap] && wf_r[cap] == rsv[j]) expd[j] = wf_d[cap];
        else if (wf_en[iss] && wf_r[iss] == rsv[j]) expd[j] = wf_d[iss];
        else expd[j] = frf[rsv[j]];
      end
    end
    k  = (ni > nf) ? ni : nf;
    dc = (k == 0) ? 1 : k + 2;
    last_ge = 1'b0; last_fe = 1'b0; last_gr = '0; last_fr = '0;
    for (int c = 0; c <= dc; c++) begin
      if (c == 0) begin
        rselector = sel; rs1 = r1; rs2 = r2; rs3 = r3;
      end else begin
        rselector = 6'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); rs3 = 5'($urandom);
      end
      enable   = (c == 0) || (c == mid_en_cyc);
      wgenable = wg_en[c]; wgreg = wg_r[c]; wgdata = wg_d[c];
      wfenable = wf_en[c]; wfreg = wf_r[c]; wfdata = wf_d[c];
      rgdata   = last_ge ? irf[last_gr] : $urandom;
      rfdata   = last_fe ? frf[last_fr] : $urandom;
      #1;
      vectors++;
      if (rgenable !== exp_ge[c] || rgreg !== exp_gr[c]) begin
        errors++;
        $display("FAIL %s int strobe cyc%0d: got en=%b reg=%0d, required en=%b reg=%0d",
                 tag, c, rgenable, rgreg, exp_ge[c], exp_gr[c]);
      end
      vectors++;
      if (rfenable !== exp_fe[c] || rfreg !== exp_fr[c]) begin
        errors++;
        $display("FAIL %s float strobe cyc%0d: got en=%b reg=%0d, required en=%b reg=%0d",
                 tag, c, rfenable, rfreg, exp_fe[c], exp_fr[c]);
      end
      vectors++;
      if (done !== (c == dc)) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b, required %b", tag, c, done, (c == dc));
      end
      if (c == dc) begin
        got = '{data1, data2, data3};
        for (int j = 0; j < 3; j++) begin
          vectors++;
          if (got[j] !== expd[j]) begin
            errors++;
            $display("FAIL %s data%0d: got %h, required %h", tag, j + 1, got[j], expd[j]);
          end
        end
      end
      last_ge = rgenable; last_gr = rgreg; last_fe = rfenable; last_fr = rfreg;
      @(posedge clk); #1;
    end
    drive_quiet();
    #1;
    got = '{data1, data2, data3};
    vectors++;
    if (done !== 1'b0 || rgenable !== 1'b0 || rfenable !== 1'b0 || got[0] !== expd[0] ||
        got[1] !== expd[1] || got[2] !== expd[2]) begin
      errors++;
      $display("FAIL %s hold: done=%b rgen=%b rfen=%b data=%h/%h/%h, required 0/0/0 %h/%h/%h",
               tag, done, rgenable, rfenable, got[0], got[1], got[2], expd[0], expd[1], expd[2]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_quiet();
    rselector = '0; rs1 = '0; rs2 = '0; rs3 = '0; rgdata = '0; rfdata = '0;
    #3;
    vectors++;
    if (done !== 1'b0 || rgenable !== 1'b0 || rfenable !== 1'b0 || rgreg !== 5'd0 ||
        rfreg !== 5'd0 || data1 !== 32'd0 || data2 !== 32'd0 || data3 !== 32'd0) begin
      errors++;
      $display("FAIL reset values: done=%b rgen=%b rfen=%b data=%h/%h/%h, required all 0",
               done, rgenable, rfenable, data1, data2, data3);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(5, "reset_idle");
  endtask

  task automatic test_three_int();
    clear_wr();
    irf[3] = 32'h33; irf[4] = 32'h44; irf[5] = 32'h55;
    run_fetch({2'd1, 2'd1, 2'd1}, 5'd3, 5'd4, 5'd5, "three_int");
    idle(2, "three_int");
  endtask

  task automatic test_mixed();
    clear_wr();
    irf[1] = 32'h1111; frf[2] = 32'h2222; irf[6] = 32'h6666;
    run_fetch({2'd1, 2'd2, 2'd1}, 5'd1, 5'd2, 5'd6, "mixed");
    idle(2, "mixed");
  endtask

  task automatic test_x0_only();
    clear_wr();
    run_fetch({2'd0, 2'd0, 2'd1}, 5'd0, 5'd9, 5'd9, "x0_only");
    idle(1, "x0_only");
    run_fetch({2'd3, 2'd0, 2'd3}, 5'd4, 5'd4, 5'd4, "unused_only");
    idle(1, "unused_only");
  endtask

  task automatic test_forward();
    irf[7] = 32'hAAAA;
    clear_wr();
    wg_en[1] = 1'b1; wg_r[1] = 5'd7; wg_d[1] = 32'h1234;
    run_fetch({2'd0, 2'd0, 2'd1}, 5'd7, 5'd0, 5'd0, "fwd_issue");
    idle(1, "fwd_issue");
    wg_en[2] = 1'b1; wg_r[2] = 5'd7; wg_d[2] = 32'h5678;
    run_fetch({2'd0, 2'd0, 2'd1}, 5'd7, 5'd0, 5'd0, "fwd_capture");
    idle(1, "fwd_capture");
    clear_wr();
    frf[0] = 32'hF00D;
    wf_en[2] = 1'b1; wf_r[2] = 5'd0; wf_d[2] = 32'hF0F0;
    run_fetch({2'd0, 2'd0, 2'd2}, 5'd0, 5'd0, 5'd0, "fwd_f0");
    idle(1, "fwd_f0");
    clear_wr();
    wg_en[1] = 1'b1; wg_r[1] = 5'd0; wg_d[1] = 32'hBAD0;
    wg_en[2] = 1'b1; wg_r[2] = 5'd0; wg_d[2] = 32'hBAD1;
    run_fetch({2'd0, 2'd1, 2'd1}, 5'd0, 5'd7, 5'd0, "nofwd_x0");
    idle(1, "nofwd_x0");
  endtask

  task automatic test_enable_ignored();
    clear_wr();
    mid_en_cyc = 2;
    irf[3] = 32'h33; irf[4] = 32'h44; irf[5] = 32'h55;
    run_fetch({2'd1, 2'd1, 2'd1}, 5'd3, 5'd4, 5'd5, "enable_ignored");
    idle(2, "enable_ignored");
    clear_wr();
  endtask

  task automatic test_reset_midop();
    clear_wr();
    rselector = {2'd1, 2'd1, 2'd1}; rs1 = 5'd3; rs2 = 5'd4; rs3 = 5'd5;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if (rgenable !== 1'b0 || rgreg !== 5'd0 || rfenable !== 1'b0 || done !== 1'b0 ||
        data1 !== 32'd0 || data2 !== 32'd0 || data3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop: rgen=%b rg=%0d done=%b data=%h/%h/%h, required all 0",
               rgenable, rgreg, done, data1, data2, data3);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(5, "after_reset");
    irf[3] = 32'h333; irf[4] = 32'h444; irf[5] = 32'h555;
    run_fetch({2'd1, 2'd1, 2'd1}, 5'd3, 5'd4, 5'd5, "fresh_after_reset");
    idle(1, "fresh_after_reset");
  endtask

  // Consecutive fetches with enable in the cycle right after DONE.
  task automatic test_back_to_back();
    clear_wr();
    for (int i = 0; i < 32; i++) begin irf[i] = $urandom; frf[i] = $urandom; end
    run_fetch({2'd2, 2'd1, 2'd2}, 5'd8, 5'd9, 5'd10, "b2b_a");
    run_fetch({2'd1, 2'd1, 2'd0}, 5'd11, 5'd11, 5'd0, "b2b_b");
    run_fetch({2'd0, 2'd0, 2'd0}, 5'd1, 5'd2, 5'd3, "b2b_c");
    run_fetch({2'd2, 2'd2, 2'd2}, 5'd0, 5'd0, 5'd1, "b2b_d");
    idle(1, "b2b");
  endtask

  task automatic test_random(input int n);
    logic [4:0] r1, r2, r3;
    for (int t = 0; t < n; t++) begin
      clear_wr();
      for (int i = 0; i < 32; i++) begin irf[i] = $urandom; frf[i] = $urandom; end
      r1 = 5'($urandom_range(0, 5)); r2 = 5'($urandom_range(0, 5)); r3 = 5'($urandom_range(0, 5));
      for (int c = 0; c < 8; c++) begin
        wg_en[c] = 1'($urandom); wg_r[c] = 5'($urandom_range(0, 5)); wg_d[c] = $urandom;
        wf_en[c] = 1'($urandom); wf_r[c] = 5'($urandom_range(0, 5)); wf_d[c] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) mid_en_cyc = $urandom_range(1, 5);
      run_fetch(6'($urandom), r1, r2, r3, "random");
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin irf[i] = '0; frf[i] = '0; end
    clear_wr();
    test_reset();
    test_three_int();
    test_mixed();
    test_x0_only();
    test_forward();
    test_enable_ignored();
    test_reset_midop();
    test_back_to_back();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
